mem_stage: RTL and testbench

// - MEM stage of the 8-bit pipeline. Sits directly downstream of the EX/MEM register (L3) and consumes its outputs.
// - Performs the data-memory read/write and handles memory-mapped I/O.
// - Inserts read wait-states and stalls upstream while it waits.
// - Contains the MEM/WB pipeline register that feeds write-back.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/mem_stage_data_ram.sv | 26 ++
 rtl/mem_stage.sv | 156 +++++++++++++++
 tb/tb_mem_stage.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared widths, MMIO defaults and MEM-stage types for the 8-bit pipeline.
package cpu_pkg;

   localparam int DATA_W    = 8;
   localparam int REGADDR_W = 3;
   localparam int CNT_W     = 3;   // wait-state counter, covers 0..7

   localparam logic [DATA_W-1:0] IO_OUT_ADDR_DEF = 8'hFF;
   localparam logic [DATA_W-1:0] IO_IN_ADDR_DEF  = 8'hFE;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_t;

   // MEM/WB pipeline register contents
   typedef struct packed {
      logic [DATA_W-1:0]    mem_data;
      logic [DATA_W-1:0]    alu_out;
      logic                 memtoreg;
      logic                 regwrite;
      logic [REGADDR_W-1:0] regwradd;
      logic [DATA_W-1:0]    m2out;
   } memwb_t;

endpackage

// File: rtl/mem_stage_data_ram.sv
// Data RAM: synchronous write, asynchronous read, contents survive reset.
module data_ram
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 8
) (
   input  logic              clk1,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write port.
   // NOTE: the array has no reset branch; clearing it would need a per-word reset network and RAM macros do not offer one.
   always_ff @(posedge clk1) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage: data-memory access, memory-mapped I/O, read wait-states with
// upstream stall, and the MEM/WB pipeline register.
module mem_stage
   import cpu_pkg::*;
#(
   parameter int                ADDR_W      = 8,
   parameter int                WAIT_STATES = 2,
   parameter logic [DATA_W-1:0] IO_OUT_ADDR = IO_OUT_ADDR_DEF,
   parameter logic [DATA_W-1:0] IO_IN_ADDR  = IO_IN_ADDR_DEF
) (
   input  logic                 clk1,
   input  logic                 rst,
   input  logic [DATA_W-1:0]    l3_B,
   input  logic [DATA_W-1:0]    l3_alu_out,
   input  logic                 l3_memwrite,
   input  logic                 l3_memread,
   input  logic                 l3_memtoreg,
   input  logic                 l3_regwrite,
   input  logic [REGADDR_W-1:0] l3_regwradd,
   input  logic [DATA_W-1:0]    l3_m2out,
   input  logic [DATA_W-1:0]    io_in,
   output logic                 stall,
   output logic [DATA_W-1:0]    io_out,
   output logic                 mem_err,
   output logic [DATA_W-1:0]    wb_mem_data,
   output logic [DATA_W-1:0]    wb_alu_out,
   output logic                 wb_memtoreg,
   output logic                 wb_regwrite,
   output logic [REGADDR_W-1:0] wb_regwradd,
   output logic [DATA_W-1:0]    wb_m2out
);

   localparam logic [CNT_W-1:0] CNT_INIT =
      CNT_W'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

   mem_state_t        state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] ram_rdata;
   logic              conflict, io_in_hit, io_out_hit, io_load, ram_load, ram_we;
   logic              bubble, capture_ram;
   memwb_t            wb_q;

   assign addr = l3_alu_out[ADDR_W-1:0];

   // Request decode; a simultaneous read+write is treated as a plain store.
   always_comb begin
      conflict   = l3_memread & l3_memwrite;
      io_in_hit  = (l3_alu_out == IO_IN_ADDR);
      io_out_hit = (l3_alu_out == IO_OUT_ADDR);
      io_load    = l3_memread & ~l3_memwrite & io_in_hit;
      ram_load   = l3_memread & ~l3_memwrite & ~io_in_hit;
      ram_we     = l3_memwrite & ~io_out_hit & ~rst;
   end

   data_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk1  (clk1),
      .we    (ram_we),
      .addr  (addr),
      .wdata (l3_B),
      .rdata (ram_rdata)
   );

   // Wait-state FSM: next state, counter, stall and MEM/WB control.
   // NOTE: every output gets a default before the case so no path leaves a signal unassigned and infers a latch.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      stall       = 1'b0;
      bubble      = 1'b0;
      capture_ram = 1'b0;
      unique case (state)
         MEM_IDLE: begin
            if (ram_load) begin
               if (WAIT_STATES == 0) begin
                  capture_ram = 1'b1;
               end else begin
                  stall     = 1'b1;
                  bubble    = 1'b1;
                  state_nxt = MEM_WAIT;
                  cnt_nxt   = CNT_INIT;
               end
            end
         end
         MEM_WAIT: begin
            if (cnt != '0) begin
               stall   = 1'b1;
               bubble  = 1'b1;
               cnt_nxt = cnt - 1'b1;
            end else begin
               capture_ram = 1'b1;
               state_nxt   = MEM_IDLE;
            end
         end
      endcase
      if (rst) begin
         stall = 1'b0;
      end
   end

   // FSM state and wait counter.
   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk1) begin
      if (rst) begin
         state <= MEM_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Memory-mapped output register and sticky read/write conflict flag.
   always_ff @(posedge clk1) begin
      if (rst) begin
         io_out  <= '0;
         mem_err <= 1'b0;
      end else begin
         if (l3_memwrite && io_out_hit) begin
            io_out <= l3_B;
         end
         if (conflict) begin
            mem_err <= 1'b1;
         end
      end
   end

   // MEM/WB register: bubble while waiting, otherwise copy the L3 fields.
   always_ff @(posedge clk1) begin
      if (rst) begin
         wb_q <= '0;
      end else if (bubble) begin
         wb_q.regwrite <= 1'b0;
         wb_q.memtoreg <= 1'b0;
      end else begin
         wb_q.alu_out  <= l3_alu_out;
         wb_q.memtoreg <= l3_memtoreg;
         wb_q.regwrite <= l3_regwrite;
         wb_q.regwradd <= l3_regwradd;
         wb_q.m2out    <= l3_m2out;
         if (capture_ram) begin
            wb_q.mem_data <= ram_rdata;
         end else if (io_load) begin
            wb_q.mem_data <= io_in;
         end
      end
   end

   assign wb_mem_data = wb_q.mem_data;
   assign wb_alu_out  = wb_q.alu_out;
   assign wb_memtoreg = wb_q.memtoreg;
   assign wb_regwrite = wb_q.regwrite;
   assign wb_regwradd = wb_q.regwradd;
   assign wb_m2out    = wb_q.m2out;

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: three instances (N=2/A=8, N=0/A=7, N=3/A=8), each
// checked every cycle against a per-instance behavioural model.
`timescale 1ns/1ps
module tb_mem_stage;

   localparam int NI = 3;

   logic clk1 = 1'b0;
   always #5 clk1 = ~clk1;

   logic       rst;
   logic [7:0] io_in;
   logic [7:0] l3_b [NI], l3_alu_out [NI], l3_m2out [NI];
   logic       l3_memwrite [NI], l3_memread [NI], l3_memtoreg [NI], l3_regwrite [NI];
   logic [2:0] l3_regwradd [NI];

   logic       stall_o [NI], mem_err_o [NI], wb_memtoreg_o [NI], wb_regwrite_o [NI];
   logic [7:0] io_out_o [NI], wb_mem_data_o [NI], wb_alu_out_o [NI], wb_m2out_o [NI];
   logic [2:0] wb_regwradd_o [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      mem_stage #(
         .ADDR_W      (g == 1 ? 7 : 8),
         .WAIT_STATES (g == 0 ? 2 : (g == 1 ? 0 : 3))
      ) u_dut (
         .clk1        (clk1),
         .rst         (rst),
         .l3_B        (l3_b[g]),
         .l3_alu_out  (l3_alu_out[g]),
         .l3_memwrite (l3_memwrite[g]),
         .l3_memread  (l3_memread[g]),
         .l3_memtoreg (l3_memtoreg[g]),
         .l3_regwrite (l3_regwrite[g]),
         .l3_regwradd (l3_regwradd[g]),
         .l3_m2out    (l3_m2out[g]),
         .io_in       (io_in),
         .stall       (stall_o[g]),
         .io_out      (io_out_o[g]),
         .mem_err     (mem_err_o[g]),
         .wb_mem_data (wb_mem_data_o[g]),
         .wb_alu_out  (wb_alu_out_o[g]),
         .wb_memtoreg (wb_memtoreg_o[g]),
         .wb_regwrite (wb_regwrite_o[g]),
         .wb_regwradd (wb_regwradd_o[g]),
         .wb_m2out    (wb_m2out_o[g])
      );
   end

   function automatic int ws_of(input int i);
      return (i == 0) ? 2 : ((i == 1) ? 0 : 3);
   endfunction

   function automatic int aw_of(input int i);
      return (i == 1) ? 7 : 8;
   endfunction

   // ---------------- behavioural model state ----------------
   logic [7:0] m_ram [NI][256];
   bit         m_known [NI][256];
   logic [7:0] m_io_out [NI], m_mem_data [NI], m_alu_out [NI], m_m2out [NI];
   logic       m_mem_err [NI], m_memtoreg [NI], m_regwrite [NI];
   logic [2:0] m_regwradd [NI];
   bit         m_data_known [NI];
   int         m_waited [NI];     // stall cycles already spent on the current load
   bit         m_stall [NI];      // expected stall of the last evaluated cycle
   logic       seen_stall [NI];   // DUT stall seen in the last evaluated cycle

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s[inst %0d] @%0t: got %0h, expected %0h", name, i, $time, act, exp);
      end
   endtask

   // One pipeline cycle: check stall mid-cycle, advance the model, check registers after the edge.
   task automatic tick();
      bit         wr, ld, io_ld, ram_ld;
      logic [7:0] a;
      int         idx;
      @(negedge clk1);
      for (int i = 0; i < NI; i++) begin
         a      = l3_alu_out[i];
         wr     = l3_memwrite[i];
         ld     = l3_memread[i] && !wr;
         io_ld  = ld && (a == 8'hFE);
         ram_ld = ld && !io_ld;
         idx    = int'(a) & ((1 << aw_of(i)) - 1);
         m_stall[i]    = !rst && ram_ld && (m_waited[i] < ws_of(i));
         seen_stall[i] = stall_o[i];
         check("stall", i, stall_o[i], m_stall[i]);
         if (rst) begin
            m_io_out[i] = 8'h00;  m_mem_err[i] = 1'b0;
            m_mem_data[i] = 8'h00; m_alu_out[i] = 8'h00; m_m2out[i] = 8'h00;
            m_memtoreg[i] = 1'b0; m_regwrite[i] = 1'b0; m_regwradd[i] = 3'd0;
            m_data_known[i] = 1'b1;
            m_waited[i] = 0;
         end else begin
            if (l3_memread[i] && wr) m_mem_err[i] = 1'b1;
            if (wr) begin
               if (a == 8'hFF) m_io_out[i] = l3_b[i];
               else begin
                  m_ram[i][idx]   = l3_b[i];
                  m_known[i][idx] = 1'b1;
               end
            end
            if (m_stall[i]) begin
               m_waited[i]++;
               m_regwrite[i] = 1'b0;
               m_memtoreg[i] = 1'b0;
            end else begin
               m_waited[i]   = 0;
               m_alu_out[i]  = a;
               m_m2out[i]    = l3_m2out[i];
               m_memtoreg[i] = l3_memtoreg[i];
               m_regwrite[i] = l3_regwrite[i];
               m_regwradd[i] = l3_regwradd[i];
               if (ram_ld) begin
                  m_mem_data[i]   = m_ram[i][idx];
                  m_data_known[i] = m_known[i][idx];
               end else if (io_ld) begin
                  m_mem_data[i]   = io_in;
                  m_data_known[i] = 1'b1;
               end
            end
         end
      end
      @(posedge clk1);
      #1;
      for (int i = 0; i < NI; i++) begin
         check("io_out",      i, io_out_o[i],      m_io_out[i]);
         check("mem_err",     i, mem_err_o[i],     m_mem_err[i]);
         check("wb_alu_out",  i, wb_alu_out_o[i],  m_alu_out[i]);
         check("wb_m2out",    i, wb_m2out_o[i],    m_m2out[i]);
         check("wb_memtoreg", i, wb_memtoreg_o[i], m_memtoreg[i]);
         check("wb_regwrite", i, wb_regwrite_o[i], m_regwrite[i]);
         check("wb_regwradd", i, wb_regwradd_o[i], m_regwradd[i]);
         if (m_data_known[i]) check("wb_mem_data", i, wb_mem_data_o[i], m_mem_data[i]);
      end
   endtask

   task automatic drive(input int i, input bit rd, input bit wr, input logic [7:0] a,
                        input logic [7:0] b, input bit mtr, input bit rw,
                        input logic [2:0] ra, input logic [7:0] m2);
      l3_memread[i]  = rd;
      l3_memwrite[i] = wr;
      l3_alu_out[i]  = a;
      l3_b[i]        = b;
      l3_memtoreg[i] = mtr;
      l3_regwrite[i] = rw;
      l3_regwradd[i] = ra;
      l3_m2out[i]    = m2;
   endtask

   task automatic nop(input int i);
      drive(i, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
   endtask

   task automatic drive_random(input int i);
      int         op, sel;
      bit         rd, wr;
      logic [7:0] a;
      op  = $urandom_range(0, 7);
      sel = $urandom_range(0, 9);
      rd  = (op <= 2) || (op == 5);
      wr  = (op == 3) || (op == 4) || (op == 5);
      if (sel <= 5)      a = 8'h10 + 8'(sel);
      else if (sel == 6) a = 8'hFE;
      else if (sel == 7) a = 8'hFF;
      else if (sel == 8) a = 8'h7F;
      else               a = 8'($urandom);
      drive(i, rd, wr, a, 8'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), 8'($urandom));
   endtask

   initial begin
      rst   = 1'b1;
      io_in = 8'h00;
      for (int i = 0; i < NI; i++) begin
         nop(i);
         m_waited[i] = 0;
         m_stall[i]  = 1'b0;
      end
      tick();
      tick();
      rst = 1'b0;
      check("rst_io_out",   0, io_out_o[0],      8'h00);
      check("rst_regwrite", 2, wb_regwrite_o[2], 1'b0);

      // Store 5A to 10 then load it on the N=2 instance.
      drive(0, 1'b0, 1'b1, 8'h10, 8'h5A, 1'b0, 1'b0, 3'd0, 8'h00);
      tick();
      drive(0, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 3'd3, 8'h00);
      tick();
      check("n2_stall_c1", 0, seen_stall[0], 1'b1);
      check("n2_bubble_c1", 0, wb_regwrite_o[0], 1'b0);
      tick();
      check("n2_stall_c2", 0, seen_stall[0], 1'b1);
      check("n2_bubble_c2", 0, wb_regwrite_o[0], 1'b0);
      tick();
      check("n2_stall_c3", 0, seen_stall[0], 1'b0);
      check("n2_load_data", 0, wb_mem_data_o[0], 8'h5A);
      check("n2_load_rw",   0, wb_regwrite_o[0], 1'b1);
      nop(0);

      // Zero wait-state load on the N=0 instance.
      drive(1, 1'b0, 1'b1, 8'h10, 8'h33, 1'b0, 1'b0, 3'd0, 8'h00);
      tick();
      drive(1, 1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b1, 3'd1, 8'h00);
      tick();
      check("n0_stall", 1, seen_stall[1], 1'b0);
      check("n0_load_data", 1, wb_mem_data_o[1], 8'h33);

      // MMIO: 7F aliases RAM word 7F on the 7-bit instance, FF must still go to io_out.
      drive(1, 1'b0, 1'b1, 8'h7F, 8'h66, 1'b0, 1'b0, 3'd0, 8'h00);
      tick();
      drive(1, 1'b0, 1'b1, 8'hFF, 8'hA5, 1'b0, 1'b0, 3'd0, 8'h00);
      tick();
      check("mmio_io_out", 1, io_out_o[1], 8'hA5);
      drive(1, 1'b1, 1'b0, 8'h7F, 8'h00, 1'b1, 1'b1, 3'd2, 8'h00);
      tick();
      check("mmio_ram_untouched", 1, wb_mem_data_o[1], 8'h66);
      io_in = 8'h3C;
      drive(0, 1'b1, 1'b0, 8'hFE, 8'h00, 1'b1, 1'b1, 3'd4, 8'h00);
      tick();
      check("io_in_stall", 0, seen_stall[0], 1'b0);
      check("io_in_data",  0, wb_mem_data_o[0], 8'h3C);
      nop(1);

      // Read/write conflict on the N=2 instance, then read back.
      drive(0, 1'b1, 1'b1, 8'h20, 8'h77, 1'b1, 1'b1, 3'd1, 8'h00);
      tick();
      check("conf_stall", 0, seen_stall[0], 1'b0);
      check("conf_err",   0, mem_err_o[0], 1'b1);
      drive(0, 1'b1, 1'b0, 8'h20, 8'h00, 1'b1, 1'b1, 3'd1, 8'h00);
      for (int k = 0; k < 3; k++) tick();
      check("conf_ram", 0, wb_mem_data_o[0], 8'h77);
      nop(0);
      tick();
      check("conf_sticky", 0, mem_err_o[0], 1'b1);

      // ALU passthrough on the N=3 instance.
      drive(2, 1'b0, 1'b0, 8'h42, 8'h00, 1'b0, 1'b1, 3'd5, 8'h11);
      tick();
      check("pass_alu", 2, wb_alu_out_o[2],  8'h42);
      check("pass_ra",  2, wb_regwradd_o[2], 3'd5);
      check("pass_m2",  2, wb_m2out_o[2],    8'h11);
      check("pass_rw",  2, wb_regwrite_o[2], 1'b1);

      // Reset on the 2nd stall cycle of an N=3 load.
      drive(2, 1'b0, 1'b1, 8'hFF, 8'hC3, 1'b0, 1'b0, 3'd0, 8'h00);
      tick();
      drive(2, 1'b1, 1'b0, 8'h30, 8'h00, 1'b1, 1'b1, 3'd6, 8'h55);
      tick();
      check("rw_stall_c1", 2, seen_stall[2], 1'b1);
      rst = 1'b1;
      tick();
      check("rw_stall_rst", 2, seen_stall[2], 1'b0);
      rst = 1'b0;
      for (int i = 0; i < NI; i++) nop(i);
      tick();
      check("rw_stall_after", 2, seen_stall[2], 1'b0);
      check("rw_io_out",      2, io_out_o[2],      8'h00);
      check("rw_regwrite",    2, wb_regwrite_o[2], 1'b0);
      check("rw_mem_data",    2, wb_mem_data_o[2], 8'h00);
      check("rw_m2out",       2, wb_m2out_o[2],    8'h00);

      // Randomized traffic; a stalled instance keeps its inputs.
      for (int c = 0; c < 1500; c++) begin
         io_in = 8'($urandom);
         rst   = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < NI; i++) begin
            if (!m_stall[i]) drive_random(i);
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
